sync_debouncer: RTL and testbench

Downstream consumer of the two-flop synchronizer output. Takes an already-synchronized, possibly bouncing level, such as a switch or button. Produces a debounced level plus single-cycle rise/fall pulses for control logic. Pure single-clock block; does not itself synchronize, so its input must come from a synchronizer stage.

---
 rtl/sync_debouncer_pkg.sv | 17 +
 rtl/sync_debouncer_if.sv | 27 ++
 rtl/sync_debouncer_edge_pulse_gen.sv | 23 ++
 rtl/sync_debouncer.sv | 107 ++++++++++
 tb/tb_sync_debouncer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sync_debouncer_pkg.sv
// rtl/sync_debouncer_pkg.sv - shared FSM state type and counter-width helper
package sync_debouncer_pkg;

  // Stable states differ from their wait states in bit 0; bit 1 tracks the committed level.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } db_state_e;

  // Counter holds 0..stable_cycles-1; keep at least one bit for the smallest legal build.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 2) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_debouncer_if.sv
// rtl/sync_debouncer_if.sv - level input and debounced outputs of the debouncer
interface sync_debouncer_if;
  logic din;
  logic sample_en;
  logic db_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output din,
    output sample_en,
    input  db_level,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  din,
    input  sample_en,
    output db_level,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/sync_debouncer_edge_pulse_gen.sv
// rtl/sync_debouncer_edge_pulse_gen.sv - registers one-cycle rise/fall pulses from level-change strobes
module sync_debouncer_edge_pulse_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic rise_stb,
  input  logic fall_stb,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Strobes only fire on the single enabled edge that commits a new level, so
  // reloading every cycle clears the pulse on the next edge whatever sample_en does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_stb;
      fall_pulse <= fall_stb & ~rise_stb;
    end
  end

endmodule

// File: rtl/sync_debouncer.sv
// rtl/sync_debouncer.sv - debounces a synchronized level and emits rise/fall pulses
module sync_debouncer
  import sync_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  sync_debouncer_if.slave bus
);

  localparam int                CNT_W       = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam db_state_e         RESET_STATE = INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             rise_stb, fall_stb;

  // State, counter, debounced level and busy flag; reset lands in the INIT_LEVEL stable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: only enabled samples advance qualification; any disagreeing sample aborts it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_stb = 1'b0;
    fall_stb = 1'b0;
    if (bus.sample_en) begin
      case (state_q)
        STABLE_LOW: begin
          if (bus.din) begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!bus.din) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = STABLE_HIGH;
            cnt_d    = '0;
            level_d  = 1'b1;
            rise_stb = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!bus.din) begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (bus.din) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = STABLE_LOW;
            cnt_d    = '0;
            level_d  = 1'b0;
            fall_stb = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RESET_STATE;
          cnt_d   = '0;
          level_d = INIT_LEVEL;
        end
      endcase
    end
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  sync_debouncer_edge_pulse_gen u_pulse (
    .clk        (clk),
    .reset_n    (reset_n),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .rise_pulse (bus.rise_pulse),
    .fall_pulse (bus.fall_pulse)
  );

  assign bus.db_level = level_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// tb/tb_sync_debouncer.sv - directed bench with run-length reference model for sync_debouncer
module tb_sync_debouncer;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  sync_debouncer_if bus0 ();
  sync_debouncer_if bus1 ();

  sync_debouncer #(.STABLE_CYCLES(S), .INIT_LEVEL(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus0)
  );

  sync_debouncer #(.STABLE_CYCLES(S), .INIT_LEVEL(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  logic din_v [2];
  logic en_v  [2];
  logic lvl_v [2];
  logic rise_v[2];
  logic fall_v[2];
  logic busy_v[2];

  assign din_v[0]  = bus0.din;        assign din_v[1]  = bus1.din;
  assign en_v[0]   = bus0.sample_en;  assign en_v[1]   = bus1.sample_en;
  assign lvl_v[0]  = bus0.db_level;   assign lvl_v[1]  = bus1.db_level;
  assign rise_v[0] = bus0.rise_pulse; assign rise_v[1] = bus1.rise_pulse;
  assign fall_v[0] = bus0.fall_pulse; assign fall_v[1] = bus1.fall_pulse;
  assign busy_v[0] = bus0.busy;       assign busy_v[1] = bus1.busy;

  // Reference: length of the current run of enabled samples disagreeing with the level.
  logic m_level[2];
  int   m_run  [2];
  logic m_rise [2];
  logic m_fall [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level[0] <= 1'b0;
      m_level[1] <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 0;
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        if (en_v[i]) begin
          if (din_v[i] != m_level[i]) begin
            if (m_run[i] + 1 >= S) begin
              m_level[i] <= din_v[i];
              m_run[i]   <= 0;
              m_rise[i]  <= din_v[i];
              m_fall[i]  <= ~din_v[i];
            end else begin
              m_run[i] <= m_run[i] + 1;
            end
          end else begin
            m_run[i] <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model db_level[%0d]", i), lvl_v[i], m_level[i]);
        chk($sformatf("model rise_pulse[%0d]", i), rise_v[i], m_rise[i]);
        chk($sformatf("model fall_pulse[%0d]", i), fall_v[i], m_fall[i]);
        chk($sformatf("model busy[%0d]", i), busy_v[i], (m_run[i] > 0) ? 1'b1 : 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus0.din       = 1'b0;
    bus0.sample_en = 1'b1;
    bus1.din       = 1'b1;
    bus1.sample_en = 1'b1;

    // 1: reset asserted mid-cycle acts immediately, release makes no pulse
    #1 rst_n = 1'b0;
    #1;
    chk("rst lvl0", bus0.db_level, 1'b0);
    chk("rst lvl1", bus1.db_level, 1'b1);
    chk("rst busy0", bus0.busy, 1'b0);
    chk("rst rise0", bus0.rise_pulse, 1'b0);
    chk("rst fall1", bus1.fall_pulse, 1'b0);
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rel rise0", bus0.rise_pulse, 1'b0);
    chk("rel rise1", bus1.rise_pulse, 1'b0);
    chk("rel lvl1", bus1.db_level, 1'b1);

    // 3: bounce 1,1,1,0 is rejected
    bus0.din = 1'b1;
    tick(3);
    chk("bounce busy", bus0.busy, 1'b1);
    chk("bounce lvl", bus0.db_level, 1'b0);
    bus0.din = 1'b0;
    tick(1);
    chk("bounce busy clr", bus0.busy, 1'b0);
    chk("bounce no rise", bus0.rise_pulse, 1'b0);
    tick(1);
    chk("bounce lvl hold", bus0.db_level, 1'b0);

    // 2: clean step, first sampled at edge k
    bus0.din = 1'b1;
    tick(1);
    chk("step busy k", bus0.busy, 1'b1);
    chk("step lvl k", bus0.db_level, 1'b0);
    tick(2);
    chk("step lvl k+2", bus0.db_level, 1'b0);
    tick(1);
    chk("step lvl k+3", bus0.db_level, 1'b1);
    chk("step rise k+3", bus0.rise_pulse, 1'b1);
    chk("step busy k+3", bus0.busy, 1'b0);
    tick(1);
    chk("step rise k+4", bus0.rise_pulse, 1'b0);
    chk("step lvl k+4", bus0.db_level, 1'b1);

    // 4: fall with sample_en every third cycle; din change while disabled is ignored
    bus0.sample_en = 1'b0;
    bus0.din       = 1'b0;
    tick(3);
    chk("slow ignore", bus0.busy, 1'b0);
    for (int j = 0; j < 4; j++) begin
      bus0.sample_en = 1'b0;
      tick(2);
      chk("slow lvl hold", bus0.db_level, 1'b1);
      bus0.sample_en = 1'b1;
      tick(1);
      if (j < 3) chk("slow lvl pre", bus0.db_level, 1'b1);
    end
    chk("slow lvl", bus0.db_level, 1'b0);
    chk("slow fall", bus0.fall_pulse, 1'b1);
    bus0.sample_en = 1'b0;
    tick(1);
    chk("slow fall clr", bus0.fall_pulse, 1'b0);
    bus0.sample_en = 1'b1;
    tick(1);

    // 6: INIT_LEVEL=1 instance falls once after four low samples
    bus1.din = 1'b0;
    tick(3);
    chk("init1 lvl pre", bus1.db_level, 1'b1);
    tick(1);
    chk("init1 lvl", bus1.db_level, 1'b0);
    chk("init1 fall", bus1.fall_pulse, 1'b1);
    tick(1);
    chk("init1 fall clr", bus1.fall_pulse, 1'b0);
    bus1.din = 1'b1;

    // 5: reset during WAIT_HIGH at cnt=2, then full requalification
    bus0.din = 1'b1;
    tick(2);
    chk("mid busy", bus0.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid rst lvl", bus0.db_level, 1'b0);
    chk("mid rst busy", bus0.busy, 1'b0);
    chk("mid rst rise", bus0.rise_pulse, 1'b0);
    chk("mid rst lvl1", bus1.db_level, 1'b1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("requal rise", bus0.rise_pulse, 1'b0);
    tick(2);
    chk("requal lvl 3", bus0.db_level, 1'b0);
    tick(1);
    chk("requal lvl 4", bus0.db_level, 1'b1);
    chk("requal rise 4", bus0.rise_pulse, 1'b1);
    tick(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
